mem_port_arbiter: RTL and testbench

Sequencer and arbiter for a single shared memory port. It lets the fetch stage (instruction reads) and the memory stage (data loads/stores) share one fixed-latency single-port memory. It serialises their accesses, issues the memory commands, returns read data with a one-cycle acknowledge, and drives per-requester stall signals into the pipeline hazard logic.

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose: serialises fetch reads and data loads/stores onto one fixed-latency single-port memory.
// Latency: issue one cycle after grant; ack at grant+2+MEM_LATENCY for reads, at grant+2 for writes.
// Backpressure: requesters hold *_req until their one-cycle *_ack; *_stall = *_req & ~*_ack.
// Ports: clock/reset (synchronous, active-low); if_* fetch read port; dm_* data load/store port;
//        mem_* command/data to the memory; busy is high whenever an access is in flight.
module mem_port_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int MEM_LATENCY = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   output logic              if_stall,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic              dm_byte,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              dm_stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic              mem_byte,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic       FETCH    = 1'b0;
   localparam logic       DATA     = 1'b1;
   localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

   state_t     state;
   state_t     state_nxt;
   logic       owner;        // requester of the access in flight
   logic       last_grant;   // owner of the most recently completed access
   logic       we_q;
   logic [3:0] cnt;
   logic       grant;
   logic       grant_id;

   // Next state and arbitration; only IDLE looks at the requesters.
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      grant_id  = FETCH;
      case (state)
         IDLE: begin
            if (if_req || dm_req) begin
               grant     = 1'b1;
               state_nxt = ISSUE;
               // A lone requester wins; under contention the one not served last wins.
               grant_id  = (if_req && dm_req) ? ~last_grant : dm_req;
            end
         end
         ISSUE:   state_nxt = we_q ? RESP : WAIT;
         WAIT:    if (cnt == 4'd0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The mem_addr/mem_wdata/mem_byte registers double as the grant latch, so they
   // are already valid in ISSUE and simply hold their value afterwards.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         owner      <= FETCH;
         last_grant <= FETCH;
         we_q       <= 1'b0;
         cnt        <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_byte   <= 1'b0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            owner <= grant_id;
            if (grant_id == DATA) begin
               we_q      <= dm_we;
               mem_byte  <= dm_byte;
               mem_addr  <= dm_addr;
               mem_wdata <= dm_wdata;
            end else begin
               we_q      <= 1'b0;
               mem_byte  <= 1'b0;
               mem_addr  <= if_addr;
            end
         end
         if (state == ISSUE && !we_q) begin
            cnt <= LAT_LOAD;
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         // Counter at zero marks the cycle the memory presents read data.
         if (state == WAIT && cnt == 4'd0) begin
            if (owner == DATA) begin
               dm_rdata <= mem_rdata;
            end else begin
               if_rdata <= mem_rdata;
            end
         end
         if (state == RESP) begin
            last_grant <= owner;
         end
      end
   end

   assign mem_en   = (state == ISSUE);
   assign mem_we   = mem_en & we_q;
   assign if_ack   = (state == RESP) && (owner == FETCH);
   assign dm_ack   = (state == RESP) && (owner == DATA);
   assign if_stall = if_req & ~if_ack;
   assign dm_stall = dm_req & ~dm_ack;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter at MEM_LATENCY 2, 1, 5 and 15 side by side.
// Latency: a transaction-level model predicts every output each cycle from grant time and access type.
// Backpressure: random requesters hold requests until ack, sometimes drop early; instance 0 also runs directed cases.
module tb_mem_port_arbiter;

   localparam int NI = 4;

   function automatic int lat_of(input int g);
      case (g)
         0:       return 2;
         1:       return 1;
         2:       return 5;
         default: return 15;
      endcase
   endfunction

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cur_inst = 0;
   bit   chk_en = 1'b0;
   bit   rand0 = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT connections, one element per instance
   logic        if_req   [NI];
   logic [15:0] if_addr  [NI];
   logic [15:0] if_rdata [NI];
   logic        if_ack   [NI];
   logic        if_stall [NI];
   logic        dm_req   [NI];
   logic        dm_we    [NI];
   logic        dm_byte  [NI];
   logic [15:0] dm_addr  [NI];
   logic [15:0] dm_wdata [NI];
   logic [15:0] dm_rdata [NI];
   logic        dm_ack   [NI];
   logic        dm_stall [NI];
   logic        mem_en   [NI];
   logic        mem_we   [NI];
   logic        mem_byte [NI];
   logic [15:0] mem_addr [NI];
   logic [15:0] mem_wdata[NI];
   logic [15:0] mem_rdata[NI];
   logic        busy     [NI];

   for (genvar g = 0; g < NI; g++) begin : gi
      mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(lat_of(g))) u_dut (
         .clock(clk), .reset(rst_n),
         .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]),
         .if_ack(if_ack[g]), .if_stall(if_stall[g]),
         .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_byte(dm_byte[g]), .dm_addr(dm_addr[g]),
         .dm_wdata(dm_wdata[g]), .dm_rdata(dm_rdata[g]), .dm_ack(dm_ack[g]), .dm_stall(dm_stall[g]),
         .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_byte(mem_byte[g]), .mem_addr(mem_addr[g]),
         .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g]));
   end

   // Samples taken at the falling edge
   int          s_cyc;
   logic        s_if_ack [NI];
   logic        s_dm_ack [NI];
   logic        s_busy   [NI];
   logic        s_en     [NI];
   logic        s_we     [NI];
   logic [15:0] s_addr   [NI];
   logic [15:0] s_wdata  [NI];
   logic [15:0] s_if_rd  [NI];
   logic [15:0] s_dm_rd  [NI];
   int          en_last0;
   logic        issue_byte0;
   int          rd_done  [NI];

   // Environment memory (behind the DUT) and the model's own view of memory
   logic [15:0] env_mem [int];
   logic [15:0] shadow  [int];
   logic [15:0] pipe    [NI][16];

   // Reference model: one pending access per instance, described by grant cycle and kind
   bit          m_act  [NI];
   int          m_tg   [NI];
   bit          m_own  [NI];   // 0 fetch, 1 data
   bit          m_we   [NI];
   bit          m_byte [NI];
   bit          m_last [NI];
   logic [15:0] m_addr [NI];
   logic [15:0] m_wdata[NI];
   logic [15:0] x_if_rd[NI];
   logic [15:0] x_dm_rd[NI];
   logic [15:0] x_maddr[NI];
   bit          x_mbyte[NI];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s (inst %0d, cycle %0d): got %h, expected %h", tag, cur_inst, cyc, got, exp);
      end
   endtask

   function automatic logic [15:0] init_word(input int g, input logic [15:0] a);
      if (a == 16'h0010) return 16'hA5C3;
      return (a * 16'h9E37) ^ (16'(g) * 16'h1111);
   endfunction

   function automatic int mkey(input int g, input logic [15:0] a);
      return g * 65536 + int'(a);
   endfunction

   function automatic logic [15:0] env_rd(input int g, input logic [15:0] a);
      return env_mem.exists(mkey(g, a)) ? env_mem[mkey(g, a)] : init_word(g, a);
   endfunction

   function automatic logic [15:0] shadow_rd(input int g, input logic [15:0] a);
      return shadow.exists(mkey(g, a)) ? shadow[mkey(g, a)] : init_word(g, a);
   endfunction

   function automatic logic [15:0] rnd_addr();
      if ($urandom_range(0, 1) == 0) return 16'($urandom);
      return 16'($urandom_range(0, 7) << 4);
   endfunction

   task automatic sample_and_check();
      s_cyc = cyc;
      for (int g = 0; g < NI; g++) begin
         int   k;
         int   ack_k;
         bit   idle_now;
         logic x_en;
         logic x_ia;
         logic x_da;
         cur_inst    = g;
         s_if_ack[g] = if_ack[g];
         s_dm_ack[g] = dm_ack[g];
         s_busy[g]   = busy[g];
         s_en[g]     = mem_en[g];
         s_we[g]     = mem_we[g];
         s_addr[g]   = mem_addr[g];
         s_wdata[g]  = mem_wdata[g];
         s_if_rd[g]  = if_rdata[g];
         s_dm_rd[g]  = dm_rdata[g];
         if (g == 0 && mem_en[0]) begin
            en_last0    = cyc;
            issue_byte0 = mem_byte[0];
         end
         idle_now = !m_act[g];
         x_en = 1'b0;
         x_ia = 1'b0;
         x_da = 1'b0;
         if (m_act[g]) begin
            k     = cyc - m_tg[g];
            ack_k = m_we[g] ? 2 : 2 + lat_of(g);
            if (k == 1) begin
               x_en       = 1'b1;
               x_maddr[g] = m_addr[g];
               x_mbyte[g] = m_byte[g];
               if (m_we[g]) begin
                  shadow[mkey(g, m_addr[g])] = m_wdata[g];
                  if (chk_en) check("issue_wdata", mem_wdata[g], m_wdata[g]);
               end
            end
            if (k == ack_k) begin
               if (m_own[g]) x_da = 1'b1; else x_ia = 1'b1;
               if (!m_we[g]) begin
                  rd_done[g]++;
                  if (m_own[g]) x_dm_rd[g] = shadow_rd(g, m_addr[g]);
                  else          x_if_rd[g] = shadow_rd(g, m_addr[g]);
               end
               m_last[g] = m_own[g];
               m_act[g]  = 1'b0;
            end
         end
         if (chk_en) begin
            check("mem_en",   mem_en[g],   x_en);
            check("mem_we",   mem_we[g],   x_en & m_we[g]);
            check("mem_addr", mem_addr[g], x_maddr[g]);
            check("mem_byte", mem_byte[g], x_mbyte[g]);
            check("if_ack",   if_ack[g],   x_ia);
            check("dm_ack",   dm_ack[g],   x_da);
            check("if_rdata", if_rdata[g], x_if_rd[g]);
            check("dm_rdata", dm_rdata[g], x_dm_rd[g]);
            check("busy",     busy[g],     !idle_now);
            check("if_stall", if_stall[g], if_req[g] & ~x_ia);
            check("dm_stall", dm_stall[g], dm_req[g] & ~x_da);
         end
         if (idle_now && rst_n && (if_req[g] || dm_req[g])) begin
            m_own[g]   = (if_req[g] && dm_req[g]) ? !m_last[g] : dm_req[g];
            m_we[g]    = m_own[g] & dm_we[g];
            m_byte[g]  = m_own[g] & dm_byte[g];
            m_addr[g]  = m_own[g] ? dm_addr[g] : if_addr[g];
            m_wdata[g] = dm_wdata[g];
            m_tg[g]    = cyc;
            m_act[g]   = 1'b1;
         end
         if (!rst_n) begin
            m_act[g]   = 1'b0;
            m_last[g]  = 1'b0;
            x_if_rd[g] = '0;
            x_dm_rd[g] = '0;
            x_maddr[g] = '0;
            x_mbyte[g] = 1'b0;
         end
      end
   endtask

   // Memory with MEM_LATENCY cycles from command to data; data is junk at other times.
   task automatic env_update();
      for (int g = 0; g < NI; g++) begin
         for (int k = 15; k >= 2; k--) pipe[g][k] = pipe[g][k-1];
         if (s_en[g] && s_we[g]) env_mem[mkey(g, s_addr[g])] = s_wdata[g];
         pipe[g][1]   = (s_en[g] && !s_we[g]) ? env_rd(g, s_addr[g]) : 16'($urandom);
         mem_rdata[g] = pipe[g][lat_of(g)];
      end
   endtask

   task automatic drive_rand(input int g);
      if (s_if_ack[g] || !if_req[g]) begin
         if_req[g]  = ($urandom_range(0, 3) != 0);
         if_addr[g] = rnd_addr();
      end else if ($urandom_range(0, 63) == 0) begin
         if_req[g] = 1'b0;
      end
      if (s_dm_ack[g] || !dm_req[g]) begin
         dm_req[g]   = ($urandom_range(0, 3) != 0);
         dm_we[g]    = 1'($urandom_range(0, 1));
         dm_byte[g]  = 1'($urandom_range(0, 1));
         dm_addr[g]  = rnd_addr();
         dm_wdata[g] = 16'($urandom);
      end else if ($urandom_range(0, 63) == 0) begin
         dm_req[g] = 1'b0;
      end
   endtask

   task automatic step();
      @(negedge clk);
      sample_and_check();
      @(posedge clk);
      #1;
      env_update();
      for (int g = 0; g < NI; g++) begin
         if (g != 0 || rand0) drive_rand(g);
      end
   endtask

   task automatic await0(input bit dm, output int at);
      bit got;
      got = 1'b0;
      at  = -1;
      for (int i = 0; i < 40 && !got; i++) begin
         step();
         if (dm ? s_dm_ack[0] : s_if_ack[0]) begin
            got = 1'b1;
            at  = s_cyc;
            if (dm) dm_req[0] = 1'b0; else if_req[0] = 1'b0;
         end
      end
      cur_inst = 0;
      check("ack_arrived", got, 1);
   endtask

   initial begin
      int       t0;
      int       at;
      int       n_ack;
      bit [3:0] order;
      for (int g = 0; g < NI; g++) begin
         if_req[g] = 0; if_addr[g] = 0; dm_req[g] = 0; dm_we[g] = 0; dm_byte[g] = 0;
         dm_addr[g] = 0; dm_wdata[g] = 0; mem_rdata[g] = 0;
         s_if_ack[g] = 0; s_dm_ack[g] = 0; s_en[g] = 0; s_we[g] = 0; s_addr[g] = 0; s_wdata[g] = 0;
         m_act[g] = 0; m_tg[g] = 0; m_own[g] = 0; m_we[g] = 0; m_byte[g] = 0; m_last[g] = 0;
         m_addr[g] = 0; m_wdata[g] = 0; x_if_rd[g] = 0; x_dm_rd[g] = 0; x_maddr[g] = 0; x_mbyte[g] = 0;
         rd_done[g] = 0;
         for (int k = 0; k < 16; k++) pipe[g][k] = 0;
      end
      en_last0 = 0;
      issue_byte0 = 0;

      // Reset; outputs are unknown until the first reset edge
      rst_n = 1'b0;
      step();
      step();
      chk_en = 1'b1;
      step();
      rst_n = 1'b1;

      // Single fetch from 0x0010
      t0 = cyc; if_addr[0] = 16'h0010; if_req[0] = 1'b1;
      await0(1'b0, at);
      check("fetch_latency", at - t0, 4);
      check("fetch_issue_cycle", en_last0 - t0, 1);
      check("fetch_rdata", s_if_rd[0], 16'hA5C3);

      // Byte store then load back
      t0 = cyc; dm_we[0] = 1'b1; dm_addr[0] = 16'h0040; dm_wdata[0] = 16'h1234; dm_byte[0] = 1'b1; dm_req[0] = 1'b1;
      await0(1'b1, at);
      check("store_latency", at - t0, 2);
      check("store_byte", issue_byte0, 1);
      t0 = cyc; dm_we[0] = 1'b0; dm_byte[0] = 1'b0; dm_req[0] = 1'b1;
      await0(1'b1, at);
      check("load_latency", at - t0, 4);
      check("load_after_store", s_dm_rd[0], 16'h1234);

      // Contention straight after reset, both re-requesting at once
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      if_addr[0] = 16'h0020; dm_addr[0] = 16'h0030; dm_we[0] = 1'b0;
      if_req[0] = 1'b1; dm_req[0] = 1'b1;
      n_ack = 0; order = '0;
      for (int i = 0; i < 60 && n_ack < 4; i++) begin
         step();
         if (s_if_ack[0] || s_dm_ack[0]) begin
            order[n_ack] = s_dm_ack[0];
            n_ack++;
         end
      end
      if_req[0] = 1'b0; dm_req[0] = 1'b0;
      cur_inst = 0;
      check("contention_acks", n_ack, 4);
      check("grant_order", order, 4'b0101);

      // Reset in the middle of a fetch read
      t0 = cyc; if_addr[0] = 16'h0010; if_req[0] = 1'b1;
      step();
      step();
      rst_n = 1'b0; if_req[0] = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      cur_inst = 0;
      check("rst_busy", s_busy[0], 0);
      check("rst_mem_addr", s_addr[0], 0);
      check("rst_mem_wdata", s_wdata[0], 0);
      check("rst_dm_rdata", s_dm_rd[0], 0);
      step();
      cur_inst = 0;
      check("no_ack_after_rst", s_if_ack[0], 0);
      t0 = cyc; if_req[0] = 1'b1;
      await0(1'b0, at);
      check("post_rst_latency", at - t0, 4);
      check("post_rst_rdata", s_if_rd[0], 16'hA5C3);

      // Load request dropped during WAIT still completes
      t0 = cyc; dm_we[0] = 1'b0; dm_addr[0] = 16'h0040; dm_req[0] = 1'b1;
      step();
      step();
      dm_req[0] = 1'b0;
      await0(1'b1, at);
      check("early_drop_latency", at - t0, 4);
      step();
      cur_inst = 0;
      check("early_drop_idle", s_busy[0], 0);

      // Random traffic on every instance with one reset in the middle
      rand0 = 1'b1;
      repeat (1200) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (1300) step();
      for (int g = 0; g < NI; g++) begin
         cur_inst = g;
         check("reads_completed", rd_done[g] > 10, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
